// File: rtl/run_seq_pkg.sv
// Shared types and default limits for the run sequencer and its memory port mux.
package run_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } seq_state_t;

    localparam int DEF_MAX_CYCLES = 4096;
    localparam int DEF_RST_CYCLES = 2;

endpackage

// File: rtl/run_sequencer_if.sv
// Host-side data memory access bus: request/write-enable/address/data with a same-cycle grant.
interface run_sequencer_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rdata
    );
endinterface

// File: rtl/run_sequencer_mem_port_mux.sv
// Combinational owner selection for the single data memory port: host, core, or parked.
module mem_port_mux
    import run_seq_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  seq_state_t    state,
    input  logic          host_gnt,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic [AW-1:0] core_addr,
    input  logic          core_re,
    input  logic          core_we,
    input  logic [DW-1:0] core_wdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata
);

    always_comb begin
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (host_gnt) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_we    = host_we;
            mem_re    = ~host_we;
        end else if (state == S_RUN) begin
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            mem_we    = core_we;
            mem_re    = core_re;
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// Holds the core in reset, releases it for one watchdog-bounded run, counts run cycles,
// and arbitrates the data memory port between the host (while stopped) and the core.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int  MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int  RST_CYCLES = DEF_RST_CYCLES,
    parameter int  AW         = 8,
    parameter int  DW         = 8,
    localparam int CW         = $clog2(MAX_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            core_done,
    output logic            core_rst,
    output logic            busy,
    output logic            finished,
    output logic            timed_out,
    output logic [CW-1:0]   cycle_count,
    run_sequencer_if.slave  host,
    input  logic [AW-1:0]   core_addr,
    input  logic            core_re,
    input  logic            core_we,
    input  logic [DW-1:0]   core_wdata,
    output logic [DW-1:0]   core_rdata,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_re,
    output logic            mem_we,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int            RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_CYCLES);

    seq_state_t    state;
    logic [RW-1:0] rst_cnt;
    logic          host_gnt;

    // The host only owns the port while the core is stopped, and a same-cycle start wins.
    assign host_gnt   = host.req & ~start & ((state == S_IDLE) | (state == S_DONE));
    assign host.gnt   = host_gnt;
    assign host.rdata = mem_rdata;
    assign core_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            rst_cnt     <= '0;
            cycle_count <= '0;
            finished    <= 1'b0;
            timed_out   <= 1'b0;
            core_rst    <= 1'b1;
            busy        <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_RESET;
                        rst_cnt     <= '0;
                        cycle_count <= '0;
                        finished    <= 1'b0;
                        timed_out   <= 1'b0;
                        core_rst    <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                S_RESET: begin
                    rst_cnt <= rst_cnt + 1'b1;
                    if (rst_cnt == RST_LAST) begin
                        state    <= S_RUN;
                        core_rst <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (core_done) begin
                        state    <= S_DONE;
                        finished <= 1'b1;
                        core_rst <= 1'b1;
                        busy     <= 1'b0;
                    end else if (cycle_count == CNT_LAST) begin
                        // Watchdog expiry reports the full limit as the run length.
                        state       <= S_DONE;
                        cycle_count <= CNT_MAX;
                        timed_out   <= 1'b1;
                        finished    <= 1'b1;
                        core_rst    <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    core_rst <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    mem_port_mux #(
        .AW(AW),
        .DW(DW)
    ) u_mux (
        .state      (state),
        .host_gnt   (host_gnt),
        .host_we    (host.we),
        .host_addr  (host.addr),
        .host_wdata (host.wdata),
        .core_addr  (core_addr),
        .core_re    (core_re),
        .core_we    (core_we),
        .core_wdata (core_wdata),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata)
    );

endmodule
